// File: rtl/input_debounce_pkg.sv
// Shared types and defaults for the input conditioning block: debounce cell
// states, default timing constants and a counter-width helper.
package input_debounce_pkg;

  typedef enum logic {
    DB_STABLE,
    DB_PENDING
  } db_state_e;

  localparam int SAMPLE_DIV_DEF = 500;
  localparam int DB_COUNT_DEF   = 4;

  // Width of a counter holding 0..n-1; never below one bit so n == 1 stays legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_debounce_cell.sv
// One-bit debouncer: flips its stable value only after DB_COUNT consecutive
// sample ticks disagree with it, and pulses rise for the first cycle at 1.
module input_debounce_cell
  import input_debounce_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync_in,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DB_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  db_state_e      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           stable_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DB_STABLE;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      stable <= stable_n;
      rise   <= stable_n & ~stable;
    end
  end

  // NOTE: every variable gets a hold default first so no path infers a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stable_n = stable;
    if (tick) begin
      unique case (state)
        DB_STABLE: begin
          if (sync_in != stable) begin
            if (DB_COUNT == 1) begin
              stable_n = ~stable;
            end else begin
              cnt_n   = CW'(1);
              state_n = DB_PENDING;
            end
          end
        end
        DB_PENDING: begin
          if (sync_in == stable) begin
            cnt_n   = '0;
            state_n = DB_STABLE;
          end else if (cnt == CNT_LAST) begin
            stable_n = ~stable;
            cnt_n    = '0;
            state_n  = DB_STABLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = DB_STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debounce_ctrl.sv
// Switch/button conditioning for the input peripheral: synchronisers, shared
// sample prescaler, per-bit debouncers, sticky press flags and level irq.
module input_debounce_ctrl
  import input_debounce_pkg::*;
#(
  parameter int N_SW       = 32,
  parameter int N_BTN      = 4,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int DB_COUNT   = DB_COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  raw_sw,
  input  logic [N_BTN-1:0] raw_btn,
  input  logic             clr_we,
  input  logic [N_BTN-1:0] clr_mask,
  input  logic [N_BTN-1:0] irq_en,
  output logic [N_SW-1:0]  sw_stable,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_pend,
  output logic             irq
);

  localparam int PW = cnt_width(SAMPLE_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);

  logic [N_SW-1:0]  sw_meta, sw_sync;
  logic [N_BTN-1:0] btn_meta, btn_sync, btn_rise;
  logic [PW-1:0]    pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
      pre_cnt  <= '0;
    end else begin
      sw_meta  <= raw_sw;
      sw_sync  <= sw_meta;
      btn_meta <= raw_btn;
      btn_sync <= btn_meta;
      pre_cnt  <= tick ? '0 : pre_cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    input_debounce_cell #(.DB_COUNT(DB_COUNT)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .sync_in (sw_sync[i]),
      .stable  (sw_stable[i]),
      .rise    ()
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    input_debounce_cell #(.DB_COUNT(DB_COUNT)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .sync_in (btn_sync[i]),
      .stable  (btn_stable[i]),
      .rise    (btn_rise[i])
    );
  end

  // A press landing in the same cycle as its clear is kept: set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_pend <= '0;
      irq      <= 1'b0;
    end else begin
      btn_pend <= (btn_pend & ~(clr_we ? clr_mask : '0)) | btn_rise;
      irq      <= |(btn_pend & irq_en);
    end
  end

endmodule

// File: tb/tb_input_debounce_ctrl.sv
// Self-checking bench for input_debounce_ctrl with SAMPLE_DIV=4, DB_COUNT=3:
// constant-expectation table, directed corner sequences, randomized vs model.
module tb_input_debounce_ctrl;

  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raw_sw;
  logic [3:0]  raw_btn;
  logic        clr_we;
  logic [3:0]  clr_mask;
  logic [3:0]  irq_en;
  logic [31:0] sw_stable;
  logic [3:0]  btn_stable;
  logic [3:0]  btn_pend;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  input_debounce_ctrl #(.N_SW(32), .N_BTN(4), .SAMPLE_DIV(SD), .DB_COUNT(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_sw     (raw_sw),
    .raw_btn    (raw_btn),
    .clr_we     (clr_we),
    .clr_mask   (clr_mask),
    .irq_en     (irq_en),
    .sw_stable  (sw_stable),
    .btn_stable (btn_stable),
    .btn_pend   (btn_pend),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: pads delayed two cycles, a sample every SD-th cycle,
  // a bit flips after DB consecutive disagreeing samples.
  logic [31:0] m_sw_meta, m_sw_sync, m_sw_st;
  logic [3:0]  m_btn_meta, m_btn_sync, m_btn_st, m_btn_prev, m_pend, m_rise;
  logic        m_irq;
  int          m_presc;
  int          m_run_sw[32];
  int          m_run_btn[4];
  bit          m_tick;

  always @(posedge clk) begin
    if (rst) begin
      m_sw_meta = '0; m_sw_sync = '0; m_sw_st = '0;
      m_btn_meta = '0; m_btn_sync = '0; m_btn_st = '0; m_btn_prev = '0;
      m_pend = '0; m_irq = 1'b0; m_presc = 0;
      for (int i = 0; i < 32; i++) m_run_sw[i] = 0;
      for (int i = 0; i < 4; i++) m_run_btn[i] = 0;
    end else begin
      m_tick     = (m_presc == SD - 1);
      m_rise     = m_btn_st & ~m_btn_prev;
      m_irq      = |(m_pend & irq_en);
      m_pend     = (m_pend & ~(clr_we ? clr_mask : 4'b0)) | m_rise;
      m_btn_prev = m_btn_st;
      if (m_tick) begin
        for (int i = 0; i < 32; i++) begin
          m_run_sw[i] = (m_sw_sync[i] != m_sw_st[i]) ? m_run_sw[i] + 1 : 0;
          if (m_run_sw[i] == DB) begin
            m_sw_st[i]  = ~m_sw_st[i];
            m_run_sw[i] = 0;
          end
        end
        for (int i = 0; i < 4; i++) begin
          m_run_btn[i] = (m_btn_sync[i] != m_btn_st[i]) ? m_run_btn[i] + 1 : 0;
          if (m_run_btn[i] == DB) begin
            m_btn_st[i]  = ~m_btn_st[i];
            m_run_btn[i] = 0;
          end
        end
      end
      m_sw_sync  = m_sw_meta;
      m_sw_meta  = raw_sw;
      m_btn_sync = m_btn_meta;
      m_btn_meta = raw_btn;
      m_presc    = m_tick ? 0 : m_presc + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_sw"},   64'(sw_stable),  64'h0);
    check({name, "_btn"},  64'(btn_stable), 64'h0);
    check({name, "_pend"}, 64'(btn_pend),   64'h0);
    check({name, "_irq"},  64'(irq),        64'h0);
  endtask

  // Steps until btn_stable[b] reads 1; lat = steps taken, -1 on timeout.
  task automatic wait_stable(input int b, input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (btn_stable[b]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic clear_all_pend();
    clr_we = 1'b1; clr_mask = 4'hF;
    step();
    clr_we = 1'b0; clr_mask = 4'h0;
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic        clr_we;
    logic [3:0]  clr_mask;
    logic [3:0]  irq_en;
    int          hold;
    logic [31:0] e_sw;
    logic [3:0]  e_btn;
    logic [3:0]  e_pend;
    logic        e_irq;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1; raw_sw = '0; raw_btn = '0; clr_we = 1'b0; clr_mask = '0; irq_en = '0;

    //           rst   sw            btn    cwe   cmask  en     hold e_sw          e_btn  e_pend e_irq
    tbl[0] = '{1'b1, 32'h0,        4'h0, 1'b0, 4'h0, 4'h0,  3, 32'h0,        4'h0, 4'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h0,        4'h0, 1'b0, 4'h0, 4'h0, 20, 32'h0,        4'h0, 4'h0, 1'b0};
    tbl[2] = '{1'b0, 32'h0,        4'h1, 1'b0, 4'h0, 4'h1, 20, 32'h0,        4'h1, 4'h1, 1'b1};
    tbl[3] = '{1'b0, 32'hA5A50F0F, 4'h1, 1'b0, 4'h0, 4'h1, 20, 32'hA5A50F0F, 4'h1, 4'h1, 1'b1};
    tbl[4] = '{1'b0, 32'hA5A50F0F, 4'h1, 1'b1, 4'h1, 4'h1,  3, 32'hA5A50F0F, 4'h1, 4'h0, 1'b0};
    tbl[5] = '{1'b0, 32'hA5A50F0F, 4'h0, 1'b0, 4'h0, 4'h1, 20, 32'hA5A50F0F, 4'h0, 4'h0, 1'b0};
    tbl[6] = '{1'b0, 32'hA5A50F0F, 4'h2, 1'b0, 4'h0, 4'h0, 20, 32'hA5A50F0F, 4'h2, 4'h2, 1'b0};
    tbl[7] = '{1'b0, 32'hA5A50F0F, 4'h2, 1'b0, 4'h0, 4'h2,  2, 32'hA5A50F0F, 4'h2, 4'h2, 1'b1};
    tbl[8] = '{1'b0, 32'hA5A50F0F, 4'h0, 1'b1, 4'hF, 4'h2, 20, 32'hA5A50F0F, 4'h0, 4'h0, 1'b0};

    @(negedge clk);
    for (int v = 0; v < 9; v++) begin
      rst = tbl[v].rst; raw_sw = tbl[v].sw; raw_btn = tbl[v].btn;
      clr_we = tbl[v].clr_we; clr_mask = tbl[v].clr_mask; irq_en = tbl[v].irq_en;
      for (int c = 0; c < tbl[v].hold; c++) step();
      check($sformatf("tbl%0d_sw", v),   64'(sw_stable),  64'(tbl[v].e_sw));
      check($sformatf("tbl%0d_btn", v),  64'(btn_stable), 64'(tbl[v].e_btn));
      check($sformatf("tbl%0d_pend", v), 64'(btn_pend),   64'(tbl[v].e_pend));
      check($sformatf("tbl%0d_irq", v),  64'(irq),        64'(tbl[v].e_irq));
    end
    clr_we = 1'b0; clr_mask = '0;

    // Reset held with pads high, then a single press after release.
    rst = 1'b1; raw_sw = '0; raw_btn = 4'b0001; irq_en = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      check_all_zero($sformatf("in_rst%0d", c));
    end
    rst = 1'b0;
    wait_stable(0, 30, lat);
    check("rst_release_lat", 64'(lat), 64'd12);
    check("rst_release_pend_before", 64'(btn_pend[0]), 64'd0);
    step();
    check("rst_release_pend", 64'(btn_pend[0]), 64'd1);
    step();
    check("rst_release_irq", 64'(irq), 64'd1);
    clear_all_pend();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (btn_pend[0]) seen = 1'b1;
    end
    check("pend_set_once", 64'(seen), 64'd0);

    // Clean press from a settled released state.
    raw_btn = 4'b0000;
    for (int c = 0; c < 20; c++) step();
    clear_all_pend();
    raw_btn = 4'b0001;
    wait_stable(0, 20, lat);
    check("press_lat_window", 64'(lat > 10 && lat <= 15), 64'd1);
    step();
    check("press_pend", 64'(btn_pend), 64'h1);
    step();
    check("press_irq", 64'(irq), 64'd1);

    // Bouncing button must never be accepted.
    clear_all_pend();
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      raw_btn[1] = ((c / 5) % 2) == 0;
      step();
      if (btn_stable[1]) seen = 1'b1;
    end
    raw_btn[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (btn_stable[1]) seen = 1'b1;
    end
    check("bounce_stable", 64'(seen), 64'd0);
    check("bounce_pend", 64'(btn_pend[1]), 64'd0);

    // Switch word moves as a whole.
    raw_sw = 32'h0; raw_btn = 4'b0000;
    for (int c = 0; c < 20; c++) step();
    raw_sw = 32'hA5A5_0F0F;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (sw_stable != 32'h0 && sw_stable != 32'hA5A5_0F0F) seen = 1'b1;
    end
    check("sw_no_partial", 64'(seen), 64'd0);
    check("sw_word", 64'(sw_stable), 64'hA5A5_0F0F);

    // Set/clear race on the rising cycle of button 2.
    clear_all_pend();
    irq_en = 4'b0100;
    raw_btn = 4'b0100;
    wait_stable(2, 30, lat);
    check("race_rise_seen", 64'(lat > 0), 64'd1);
    clr_we = 1'b1; clr_mask = 4'b0100;
    step();
    clr_we = 1'b0; clr_mask = 4'b0000;
    check("race_set_wins", 64'(btn_pend[2]), 64'd1);
    step();
    check("race_irq_up", 64'(irq), 64'd1);
    clr_we = 1'b1; clr_mask = 4'b0100;
    step();
    clr_we = 1'b0; clr_mask = 4'b0000;
    check("race_cleared", 64'(btn_pend[2]), 64'd0);
    check("race_irq_lag", 64'(irq), 64'd1);
    step();
    check("race_irq_down", 64'(irq), 64'd0);

    // Reset after two of three ticks: the count must start over.
    rst = 1'b1; raw_btn = 4'b0000;
    step(); step();
    raw_btn = 4'b1000; rst = 1'b0;
    for (int c = 0; c < 9; c++) step();
    check("midcnt_pre_rst", 64'(btn_stable[3]), 64'd0);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check_all_zero($sformatf("midcnt_rst%0d", c));
    end
    rst = 1'b0;
    wait_stable(3, 30, lat);
    check("midcnt_fresh_lat", 64'(lat), 64'd12);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) raw_sw = raw_sw ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) raw_sw = $urandom;
      if ($urandom_range(0, 19) == 0) raw_btn = raw_btn ^ (4'h1 << $urandom_range(0, 3));
      clr_we   = ($urandom_range(0, 7) == 0);
      clr_mask = 4'($urandom);
      if ($urandom_range(0, 49) == 0) irq_en = 4'($urandom);
      step();
      check("rnd_sw",   64'(sw_stable),  64'(m_sw_st));
      check("rnd_btn",  64'(btn_stable), 64'(m_btn_st));
      check("rnd_pend", 64'(btn_pend),   64'(m_pend));
      check("rnd_irq",  64'(irq),        64'(m_irq));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
